// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage data-RAM access controller:
// byte-lane bus width, FSM state encodings and the default timeout.
package mem_access_ctrl_pkg;

  localparam int MEM_SEL_BUS_WIDTH   = 4;
  localparam int RAM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_WAIT = 2'd2,
    MEM_ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller. It turns a load/store from EXMEM into a
// req/gnt/rvalid transaction on the data-RAM port, stalls the pipeline
// while the access is outstanding, and holds the captured load data for MEMWB.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = RAM_TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         stall_next_stage,
  input  logic                         mem_read_flag_in,
  input  logic                         mem_write_flag_in,
  input  logic [MEM_SEL_BUS_WIDTH-1:0] mem_sel_in,
  input  logic [31:0]                  mem_addr_in,
  input  logic [31:0]                  mem_write_data_in,
  output logic                         ram_req,
  output logic                         ram_we,
  output logic [MEM_SEL_BUS_WIDTH-1:0] ram_be,
  output logic [31:0]                  ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic                         ram_gnt,
  input  logic                         ram_rvalid,
  input  logic [31:0]                  ram_rdata,
  output logic [31:0]                  ram_read_data_out,
  output logic                         mem_done,
  output logic                         stall_request,
  output logic                         bus_error
);

  mem_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rbuf_q, rbuf_d;
  logic                 discard_q, discard_d;
  logic                 load_q, load_d;
  logic                 err_q, err_d;

  logic access;
  logic timeout;
  logic unused_addr_bits;

  // A simultaneous read and write flag is treated as a write.
  assign access           = mem_read_flag_in | mem_write_flag_in;
  assign timeout          = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));
  assign unused_addr_bits = ^mem_addr_in[1:0];

  // State, counter, read buffer and flags register with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MEM_ST_IDLE;
      cnt_q     <= '0;
      rbuf_q    <= '0;
      discard_q <= 1'b0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rbuf_q    <= rbuf_d;
      discard_q <= discard_d;
      load_q    <= load_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: flush before grant aborts cleanly, flush after grant
  // only marks the access discarded, rvalid beats a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rbuf_d    = rbuf_q;
    discard_d = discard_q;
    load_d    = load_q;
    err_d     = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        if (access && !flush) begin
          state_d   = MEM_ST_REQ;
          cnt_d     = '0;
          discard_d = 1'b0;
        end
      end
      MEM_ST_REQ: begin
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        load_d = mem_read_flag_in & ~mem_write_flag_in;
        if (flush && !ram_gnt) begin
          state_d = MEM_ST_IDLE;
        end else if (timeout) begin
          state_d = MEM_ST_DONE;
          err_d   = 1'b1;
          rbuf_d  = '0;
        end else if (ram_gnt) begin
          state_d = MEM_ST_WAIT;
          if (flush) begin
            discard_d = 1'b1;
          end
        end
      end
      MEM_ST_WAIT: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (flush) begin
          discard_d = 1'b1;
        end
        if (ram_rvalid) begin
          state_d = MEM_ST_DONE;
          if (load_q && !discard_q && !flush) begin
            rbuf_d = ram_rdata;
          end
        end else if (timeout) begin
          state_d = MEM_ST_DONE;
          err_d   = 1'b1;
          if (!discard_q && !flush) begin
            rbuf_d = '0;
          end
        end
      end
      MEM_ST_DONE: begin
        if (!stall_next_stage) begin
          state_d = MEM_ST_IDLE;
        end
      end
      default: begin
        state_d = MEM_ST_IDLE;
      end
    endcase
  end

  // Bus, stall and completion outputs decoded from the current state.
  always_comb begin
    ram_req       = 1'b0;
    ram_we        = 1'b0;
    ram_be        = '0;
    ram_addr      = '0;
    ram_wdata     = '0;
    stall_request = 1'b0;
    mem_done      = 1'b0;
    case (state_q)
      MEM_ST_IDLE: begin
        stall_request = access & ~flush & ~rst;
      end
      MEM_ST_REQ: begin
        ram_req       = 1'b1;
        ram_we        = mem_write_flag_in;
        ram_be        = mem_sel_in;
        ram_addr      = {mem_addr_in[31:2], 2'b00};
        ram_wdata     = mem_write_data_in;
        stall_request = 1'b1;
      end
      MEM_ST_WAIT: begin
        stall_request = 1'b1;
      end
      MEM_ST_DONE: begin
        mem_done = ~discard_q;
      end
      default: begin
        stall_request = 1'b0;
      end
    endcase
  end

  assign ram_read_data_out = rbuf_q;
  assign bus_error         = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short timeout so the abort path
// is reachable quickly.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        stall_next_stage = 1'b0;
  logic        mem_read_flag_in = 1'b0;
  logic        mem_write_flag_in = 1'b0;
  logic [3:0]  mem_sel_in = '0;
  logic [31:0] mem_addr_in = '0;
  logic [31:0] mem_write_data_in = '0;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_gnt = 1'b0;
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic [31:0] ram_read_data_out;
  logic        mem_done;
  logic        stall_request;
  logic        bus_error;

  int checkCount = 0;
  int errorCount = 0;
  int stallCycles;
  int reqCycles;
  int doneCycles;

  mem_access_ctrl #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall_next_stage  (stall_next_stage),
    .mem_read_flag_in  (mem_read_flag_in),
    .mem_write_flag_in (mem_write_flag_in),
    .mem_sel_in        (mem_sel_in),
    .mem_addr_in       (mem_addr_in),
    .mem_write_data_in (mem_write_data_in),
    .ram_req           (ram_req),
    .ram_we            (ram_we),
    .ram_be            (ram_be),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_gnt           (ram_gnt),
    .ram_rvalid        (ram_rvalid),
    .ram_rdata         (ram_rdata),
    .ram_read_data_out (ram_read_data_out),
    .mem_done          (mem_done),
    .stall_request     (stall_request),
    .bus_error         (bus_error)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive every DUT input for the current cycle, then let outputs settle.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic gnt,
                               input logic rv, input logic [31:0] rdata,
                               input logic fl, input logic sns);
    mem_read_flag_in  = rd;
    mem_write_flag_in = wr;
    mem_sel_in        = sel;
    mem_addr_in       = addr;
    mem_write_data_in = wdata;
    ram_gnt           = gnt;
    ram_rvalid        = rv;
    ram_rdata         = rdata;
    flush             = fl;
    stall_next_stage  = sns;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle;
    @(posedge clk);
    #2;
  endtask

  // Zero-wait load used to preload the read buffer with a known value.
  task automatic loadZeroWait(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1, 0, 4'hF, addr, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, addr, 0, 1, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, addr, 0, 0, 1, data, 0, 0);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;
  endtask

  initial begin
    $display("[TB] start");
    #12;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_req", {31'b0, ram_req}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall_request}, 32'd0);
    checkOutput("rst_data", ram_read_data_out, 32'h0);
    checkOutput("rst_done", {31'b0, mem_done}, 32'd0);
    checkOutput("rst_err", {31'b0, bus_error}, 32'd0);
    rst = 1'b0;
    nextCycle;

    // Zero-wait load.
    stallCycles = 0;
    reqCycles   = 0;
    doneCycles  = 0;
    applyStimulus(1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput("ld_idle_stall", {31'b0, stall_request}, 32'd1);
    stallCycles += int'(stall_request);
    reqCycles   += int'(ram_req);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h100, 0, 1, 0, 0, 0, 0);
    checkOutput("ld_addr", ram_addr, 32'h100);
    checkOutput("ld_be", {28'b0, ram_be}, 32'hF);
    checkOutput("ld_we", {31'b0, ram_we}, 32'd0);
    stallCycles += int'(stall_request);
    reqCycles   += int'(ram_req);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    stallCycles += int'(stall_request);
    reqCycles   += int'(ram_req);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ld_data", ram_read_data_out, 32'hDEADBEEF);
    stallCycles += int'(stall_request);
    reqCycles   += int'(ram_req);
    doneCycles  += int'(mem_done);
    nextCycle;
    stallCycles += int'(stall_request);
    doneCycles  += int'(mem_done);
    checkOutput("ld_stall_cycles", stallCycles, 32'd3);
    checkOutput("ld_req_cycles", reqCycles, 32'd1);
    checkOutput("ld_done_pulses", doneCycles, 32'd1);

    // Store with two grant waits and three response waits.
    applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, 0, 0, 0, 0, 0);
    nextCycle;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, (i == 2), 0, 0, 0, 0);
      checkOutput("st_req", {31'b0, ram_req}, 32'd1);
      nextCycle;
    end
    applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, 0, 0, 0, 0, 0);
    checkOutput("st_we_dropped", {31'b0, ram_we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, 0, (i == 2), 32'h12345678, 0, 0);
      checkOutput("st_wait_stall", {31'b0, stall_request}, 32'd1);
      nextCycle;
    end
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("st_done", {31'b0, mem_done}, 32'd1);
    checkOutput("st_buf_kept", ram_read_data_out, 32'hDEADBEEF);
    nextCycle;

    // Store bus fields are sampled in a separate short store.
    applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, 1, 0, 0, 0, 0);
    checkOutput("st_we", {31'b0, ram_we}, 32'd1);
    checkOutput("st_be", {28'b0, ram_be}, 32'h3);
    checkOutput("st_addr", ram_addr, 32'h204);
    checkOutput("st_wdata", ram_wdata, 32'h0000ABCD);
    nextCycle;
    applyStimulus(0, 1, 4'b0011, 32'h207, 32'h0000ABCD, 0, 1, 32'h0, 0, 0);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;

    // Load completes while downstream is stalled for four cycles.
    applyStimulus(1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h300, 0, 1, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h300, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    nextCycle;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0, 1);
      checkOutput("ds_done", {31'b0, mem_done}, 32'd1);
      checkOutput("ds_no_req", {31'b0, ram_req}, 32'd0);
      checkOutput("ds_stall", {31'b0, stall_request}, 32'd0);
      checkOutput("ds_data", ram_read_data_out, 32'hCAFEF00D);
      nextCycle;
    end
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ds_last_done", {31'b0, mem_done}, 32'd1);
    nextCycle;
    checkOutput("ds_idle", {31'b0, mem_done}, 32'd0);

    // Timeout: grant never arrives; nine REQ cycles (count 0..8) then abort.
    applyStimulus(1, 0, 4'hF, 32'h400, 0, 0, 0, 0, 0, 0);
    nextCycle;
    reqCycles = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus_error) break;
      reqCycles += int'(ram_req);
      nextCycle;
    end
    checkOutput("to_err", {31'b0, bus_error}, 32'd1);
    checkOutput("to_req_cycles", reqCycles, 32'd9);
    checkOutput("to_done", {31'b0, mem_done}, 32'd1);
    checkOutput("to_data", ram_read_data_out, 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;
    checkOutput("to_err_pulse", {31'b0, bus_error}, 32'd0);
    checkOutput("to_idle_stall", {31'b0, stall_request}, 32'd0);

    // Flush before grant aborts back to IDLE.
    applyStimulus(1, 0, 4'hF, 32'h500, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h500, 0, 0, 0, 0, 1, 0);
    checkOutput("fl_req_stall", {31'b0, stall_request}, 32'd1);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_abort_stall", {31'b0, stall_request}, 32'd0);
    checkOutput("fl_abort_req", {31'b0, ram_req}, 32'd0);
    nextCycle;
    checkOutput("fl_abort_done", {31'b0, mem_done}, 32'd0);

    // Flush coincident with grant: access completes discarded.
    loadZeroWait(32'h600, 32'h11223344);
    checkOutput("fg_preload", ram_read_data_out, 32'h11223344);
    applyStimulus(1, 0, 4'hF, 32'h700, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h700, 0, 1, 0, 0, 1, 0);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 1, 32'h99999999, 0, 0);
    checkOutput("fg_wait_stall", {31'b0, stall_request}, 32'd1);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fg_done", {31'b0, mem_done}, 32'd0);
    checkOutput("fg_buf", ram_read_data_out, 32'h11223344);
    nextCycle;

    // Asynchronous reset in WAIT; a late rvalid is ignored.
    applyStimulus(1, 0, 4'hF, 32'h800, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h800, 0, 1, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 0, 4'hF, 32'h800, 0, 0, 0, 0, 0, 0);
    checkOutput("rw_wait_stall", {31'b0, stall_request}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rw_stall", {31'b0, stall_request}, 32'd0);
    checkOutput("rw_data", ram_read_data_out, 32'h0);
    checkOutput("rw_req", {31'b0, ram_req}, 32'd0);
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 1, 32'h55555555, 0, 0);
    nextCycle;
    applyStimulus(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rw_late_data", ram_read_data_out, 32'h0);
    checkOutput("rw_late_done", {31'b0, mem_done}, 32'd0);
    checkOutput("rw_late_stall", {31'b0, stall_request}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data-RAM access controller. Sits between the EXMEM pipeline register and MEMWB.
- Turns a load/store flagged by EX into a req/gnt/rvalid transaction on the data-RAM port and raises a stall request while the access is outstanding.
- Captures load data and presents it to MEMWB (`ram_read_data_in`) with the memory-control flags passed through unchanged.

Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles spent in REQ+WAIT before a bus error is forced.
- `CNT_WIDTH`, 8: width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  exception flush of the MEM stage
- `stall_next_stage`  in  1  MEMWB/WB cannot accept
- `mem_read_flag_in`  in  1  load in MEM
- `mem_write_flag_in`  in  1  store in MEM
- `mem_sel_in`  in  4  byte-lane mask, already lane-aligned by EX
- `mem_addr_in`  in  32  effective address
- `mem_write_data_in`  in  32  lane-aligned store data
- `ram_req`  out  1  bus request
- `ram_we`  out  1  write enable
- `ram_be`  out  4  byte enables
- `ram_addr`  out  32  word address (bits [1:0] forced 0)
- `ram_wdata`  out  32  store data
- `ram_gnt`  in  1  request accepted
- `ram_rvalid`  in  1  response (read data or write ack)
- `ram_rdata`  in  32  read data
- `ram_read_data_out`  out  32  captured load data to MEMWB
- `mem_done`  out  1  access completed this cycle
- `stall_request`  out  1  to pipeline control: hold IF..MEM
- `bus_error`  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset (`rst` high, async, any state): `state`=IDLE, `cnt`=0, read buffer=0; outputs `ram_req`/`ram_we`/`ram_be`/`ram_addr`/`ram_wdata`=0, `stall_request`=0, `mem_done`=0, `bus_error`=0.
- `access` = `mem_read_flag_in` | `mem_write_flag_in`. If both flags are set, treat the access as a write.
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `access` & !`flush`: go to REQ next cycle; `stall_request`=1 combinationally in this same cycle.
  - No access, or `flush`: stay in IDLE; `stall_request`=0.
- **REQ**
  - `ram_req`=1. `ram_we`, `ram_be`=`mem_sel_in`, `ram_addr`, `ram_wdata` are driven from the inputs, which are held stable by the stall.
  - `ram_gnt`: go to WAIT.
  - `flush` & !`ram_gnt`: abort to IDLE with no bus effect; `stall_request` drops the next cycle.
  - `flush` & `ram_gnt` in the same cycle: the transaction is committed; go to WAIT and mark the access discarded.
- **WAIT**
  - `ram_req`=0.
  - `ram_rvalid`: capture `ram_rdata` into the buffer on loads only (stores leave the buffer unchanged); go to DONE.
  - `ram_rvalid` may arrive the cycle after `gnt` (minimum) or later. An `rvalid` coincident with `gnt` while in REQ is illegal and is not sampled.
- **DONE**
  - `stall_request`=0, `mem_done`=1.
  - !`stall_next_stage`: go to IDLE.
  - `stall_next_stage`: hold DONE, keep the buffer and keep `stall_request`=0, so upstream freezes via the pipeline control's own stall.
  - Discarded access (flushed after `gnt`): `mem_done`=0 and the buffer is not updated.
- `stall_request`=1 in REQ and WAIT, and in IDLE when `access` & !`flush`.
- Minimum load latency with zero-wait RAM (`gnt` in REQ, `rvalid` the next cycle): 3 stall cycles (IDLE→REQ→WAIT→DONE).
- Timeout:
  - `cnt` clears on entering REQ and increments every cycle in REQ or WAIT.
  - When `cnt`==`TIMEOUT_CYCLES`: go to DONE, `bus_error`=1 for one cycle, read buffer=`32'h0`, `mem_done`=1.
  - A timeout in the same cycle as `rvalid`: `rvalid` wins, no error.
- `flush` while in WAIT: ignored for bus purposes; the access completes as discarded.
- `ram_read_data_out` reflects the buffer register; it changes only on a load capture, a timeout, or reset.

Decomposition:
- Shared bus header gains `MEM_SEL_BUS_WIDTH`=4 (if missing), state encodings `MEM_ST_IDLE`/`REQ`/`WAIT`/`DONE` (2-bit), and `RAM_TIMEOUT_DEFAULT`.
- No sub-module. FSM, counter and data buffer live in one module; the read buffer may reuse the existing pipeline flop cell.

Test Plan:
- Zero-wait load: addr `0x100`, sel `4'hF`, `gnt` in REQ, `rvalid`+rdata `0xDEADBEEF` the next cycle → `ram_req` high 1 cycle, `stall_request` high 3 cycles, `ram_read_data_out`=`0xDEADBEEF`, `mem_done` pulses once.
- Store with waits: sel `4'b0011`, wdata `0x0000ABCD`, `gnt` after 2 cycles, `rvalid` 3 cycles later → `ram_we`=1, `ram_be`=`0011`, `ram_addr`=`0x...0`, buffer unchanged, stall held through WAIT.
- Downstream stall: load completes while `stall_next_stage`=1 for 4 cycles → FSM stays in DONE, data stable, no second request issued.
- Timeout: `TIMEOUT_CYCLES`=8, `gnt` never asserted → `bus_error` pulses at cycle 8, data `0`, FSM returns to IDLE.
- Flush: `flush` in REQ before `gnt` → IDLE, no `rvalid` expected. `flush` coincident with `gnt` → completes, `mem_done`=0, buffer keeps its old value.
- Reset mid-WAIT: `rst` pulse asynchronously → all outputs 0 immediately; late `rvalid` ignored in IDLE.
